control_unit_ext: RTL and testbench

Parametrised successor of the CPU control unit. Generates the F1–F55 control word from the instruction register fields and status flags, and sequences the fetch, indirect, execute and interrupt cycles. It adds three things: a configurable timing-step count, a memory-ready stall handshake, and a fourth cycle for interrupts gated by an interrupt-enable flip-flop. It sits between the IR/flag logic and the datapath.

---
 rtl/control_unit_ext.sv | 134 +++++++++++++
 tb/tb_control_unit_ext.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_ext.sv
// control_unit_ext: control-word generator and fetch/indirect/execute/interrupt sequencer
// with a configurable step count, memory-ready stalls and an interrupt-enable flip-flop.
module control_unit_ext #(
   parameter int T_W      = 2,
   parameter int T_MAX    = 3,
   parameter int D_W      = 12,
   parameter bit INT_EN   = 1'b1,
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [2:0]     op_code,
   input  logic           i_bit,
   input  logic [D_W-1:0] d_bits,
   input  logic           ac_is_zero,
   input  logic           ac_is_neg,
   input  logic           e_is_zero,
   input  logic           mdr_is_zero,
   input  logic           fgi,
   input  logic           fgo,
   input  logic           s_in,
   input  logic           mem_ready,
   output logic [55:1]    control_word,
   output logic           mem_req,
   output logic [1:0]     cycle,
   output logic [T_W-1:0] t_step,
   output logic           running,
   output logic           ien
);
   typedef enum logic [1:0] {FETCH = 2'b00, INDIR = 2'b01, EXEC = 2'b10, INTR = 2'b11} cyc_t;
   localparam logic [T_W-1:0] T_LAST = T_W'(T_MAX);

   cyc_t cyc_q, cyc_d, nxt;
   logic [T_W-1:0] t_q, t_d;
   logic run_q, run_d, ien_q, ien_d;
   logic [55:1] cw;
   logic mreq, stall, t0, t1, t2, t3, last, irm_ind, irr, ies, go_int;
   logic [7:0] op;
   logic [11:0] irr_en;
   logic unused_ok;

   assign op      = 8'b1 << op_code;
   assign t0      = t_q == T_W'(0);
   assign t1      = t_q == T_W'(1);
   assign t2      = t_q == T_W'(2);
   assign t3      = t_q == T_W'(3);
   assign last    = t_q == T_LAST;
   assign irm_ind = ~op[7] & i_bit;
   assign irr     = op[7] & ~i_bit;
   assign ies     = op[7] & i_bit;
   assign go_int  = INT_EN & ien_q & (fgi | fgo);
   // skip bits SPA/SNA/SZA/SZE fire only when their condition holds
   assign irr_en    = d_bits[11:0] & {7'h7f, ~ac_is_neg, ac_is_neg, ac_is_zero, e_is_zero, 1'b1};
   assign unused_ok = ^{mdr_is_zero, d_bits};

   always_comb begin
      cw   = '0;
      mreq = 1'b0;
      nxt  = FETCH;
      case (cyc_q)
         FETCH: begin
            cw[1] = t0;
            cw[2] = t1;
            cw[3] = t2;
            cw[4] = last & irm_ind;
            cw[5] = last & ~irm_ind;
            mreq  = t1;
            nxt   = irm_ind ? INDIR : EXEC;
         end
         INDIR: begin
            cw[6] = t0;
            cw[7] = t1;
            cw[9] = last;
            mreq  = t1;
            nxt   = EXEC;
         end
         EXEC: begin
            cw[12:10] = {3{op[0]}} & {t2, t1, t0};
            cw[16:14] = {3{op[1]}} & {t2, t1, t0};
            cw[19:17] = {3{op[2]}} & {t2, t1, t0};
            cw[22:20] = {3{op[3]}} & {t2, t1, t0};
            cw[23]    = op[4] & t0;
            cw[26:24] = {3{op[5]}} & {t2, t1, t0};
            cw[30:27] = {4{op[6]}} & {t3, t2, t1, t0};
            for (int k = 0; k < 12; k++)
               cw[42-k] = irr & t0 & irr_en[k];
            cw[46:43] = {4{ies & t0}} & {d_bits[8] & fgo, d_bits[9] & fgi, d_bits[10], d_bits[11]};
            cw[49:47] = {3{ies & d_bits[7]}} & {t2, t1, t0};
            cw[51:50] = {2{ies & t0}} & {d_bits[5], d_bits[6]};
            cw[52]    = last & go_int;
            cw[13]    = last & ~go_int;
            mreq      = t1 & (|op[2:0] | op[5] | op[6] | (ies & d_bits[7])) | t2 & op[3] | t3 & op[6];
            nxt       = go_int ? INTR : FETCH;
         end
         INTR: begin
            cw[53] = t0;
            cw[54] = t1;
            cw[55] = last;
            mreq   = t1;
         end
      endcase
      cw[55:50] = cw[55:50] & {6{INT_EN}};
      mreq      = mreq & run_q;
      stall     = mreq & MEM_WAIT & ~mem_ready;
      // a stalled step emits nothing; its F signals fire in the clock memory completes
      cw        = (run_q & ~stall) ? cw : '0;
      run_d     = s_in | (run_q & ~cw[42]);
      ien_d     = (ien_q | cw[50]) & ~cw[51] & ~cw[55];
      t_d       = (run_q & ~stall) ? (last ? '0 : t_q + 1'b1) : t_q;
      cyc_d     = (run_q & ~stall & last) ? nxt : cyc_q;
      t_d       = run_d ? t_d : '0;
      cyc_d     = run_d ? cyc_d : FETCH;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cyc_q <= FETCH;
         t_q   <= '0;
         run_q <= 1'b0;
         ien_q <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         t_q   <= t_d;
         run_q <= run_d;
         ien_q <= ien_d;
      end

   assign control_word = cw;
   assign mem_req      = mreq;
   assign cycle        = cyc_q;
   assign t_step       = t_q;
   assign running      = run_q;
   assign ien          = ien_q;
endmodule

// File: tb/tb_control_unit_ext.sv
// tb_control_unit_ext: randomized bench for control_unit_ext; each instruction is expanded into
// an expected per-step list of F numbers from the cycle rules and compared every clock.
module tb_control_unit_ext;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [2:0] op_code = '0;
   logic [11:0] d_bits = '0;
   logic i_bit = 1'b0, ac_is_zero = 1'b0, ac_is_neg = 1'b0, e_is_zero = 1'b0, mdr_is_zero = 1'b0;
   logic fgi = 1'b0, fgo = 1'b0, s_in = 1'b0, mem_ready = 1'b0;
   logic [55:1] cw_a, cw_b, o_cw;
   logic mreq_a, mreq_b, run_a, run_b, ien_a, ien_b, o_mreq, o_run, o_ien;
   logic [1:0] cyc_a, cyc_b, t_a, o_cyc;
   logic [2:0] t_b, o_t;
   bit sel5 = 1'b0;
   int total = 0, bad = 0;

   typedef struct packed {logic [55:1] cw; logic mem; logic [1:0] cyc; logic [2:0] t; logic ien;} step_t;
   step_t q[$];
   bit m_ien = 1'b0, m_run = 1'b0;

   control_unit_ext dut_a (.clk(clk), .reset_n(reset_n), .op_code(op_code), .i_bit(i_bit), .d_bits(d_bits),
      .ac_is_zero(ac_is_zero), .ac_is_neg(ac_is_neg), .e_is_zero(e_is_zero), .mdr_is_zero(mdr_is_zero),
      .fgi(fgi), .fgo(fgo), .s_in(s_in), .mem_ready(mem_ready), .control_word(cw_a), .mem_req(mreq_a),
      .cycle(cyc_a), .t_step(t_a), .running(run_a), .ien(ien_a));

   control_unit_ext #(.T_W(3), .T_MAX(5)) dut_b (.clk(clk), .reset_n(reset_n), .op_code(op_code),
      .i_bit(i_bit), .d_bits(d_bits), .ac_is_zero(ac_is_zero), .ac_is_neg(ac_is_neg), .e_is_zero(e_is_zero),
      .mdr_is_zero(mdr_is_zero), .fgi(fgi), .fgo(fgo), .s_in(s_in), .mem_ready(mem_ready),
      .control_word(cw_b), .mem_req(mreq_b), .cycle(cyc_b), .t_step(t_b), .running(run_b), .ien(ien_b));

   assign o_cw   = sel5 ? cw_b : cw_a;
   assign o_mreq = sel5 ? mreq_b : mreq_a;
   assign o_cyc  = sel5 ? cyc_b : cyc_a;
   assign o_t    = sel5 ? t_b : {1'b0, t_a};
   assign o_run  = sel5 ? run_b : run_a;
   assign o_ien  = sel5 ? ien_b : ien_a;

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("timeout: bench did not finish");
      $fatal(1, "watchdog");
   end

   // Expand one instruction into its expected step list (state in effect at each step).
   task automatic build(input logic [2:0] op, input logic ib, input logic [11:0] d,
                        input logic fi, fo, sv, an, az, ez);
      int tm = sel5 ? 5 : 3;
      int fb[7] = '{10, 14, 17, 20, 23, 24, 27};
      int fl[7] = '{3, 3, 3, 3, 1, 3, 4};
      logic [55:1] w;
      logic ind, irr, ies, go, cur, mem, hlt;
      ind = op != 3'd7 && ib;
      irr = op == 3'd7 && !ib;
      ies = op == 3'd7 && ib;
      cur = m_ien;
      go  = 1'b0;
      hlt = 1'b0;
      q.delete();
      for (int t = 0; t <= tm; t++) begin
         w = '0;
         if (t < 3) w[t + 1] = 1'b1;
         else if (t == tm) w[ind ? 4 : 5] = 1'b1;
         q.push_back('{w, t == 1, 2'b00, 3'(t), cur});
      end
      if (ind)
         for (int t = 0; t <= tm; t++) begin
            w = '0;
            if (t == 0) w[6] = 1'b1;
            else if (t == 1) w[7] = 1'b1;
            else if (t == tm) w[9] = 1'b1;
            q.push_back('{w, t == 1, 2'b01, 3'(t), cur});
         end
      for (int t = 0; t <= tm && !hlt; t++) begin
         w = '0;
         mem = 1'b0;
         if (op != 3'd7 && t < fl[op]) begin
            w[fb[op] + t] = 1'b1;
            mem = (t == 1 && op != 3'd3) || (t == 2 && op == 3'd3) || t == 3;
         end
         if (irr && t == 0)
            for (int k = 0; k < 12; k++)
               w[42 - k] = d[k] && (k == 4 ? !an : k == 3 ? an : k == 2 ? az : k == 1 ? ez : 1'b1);
         if (ies && t == 0) begin
            w[43] = d[11];
            w[44] = d[10];
            w[45] = d[9] & fi;
            w[46] = d[8] & fo;
            w[50] = d[6];
            w[51] = d[5];
         end
         if (ies && d[7] && t < 3) begin
            w[47 + t] = 1'b1;
            mem = t == 1;
         end
         if (t == tm) begin
            go = cur && (fi || fo);
            w[go ? 52 : 13] = 1'b1;
         end
         q.push_back('{w, mem, 2'b10, 3'(t), cur});
         if (ies && t == 0) cur = (cur | d[6]) & ~d[5];
         if (irr && t == 0 && d[0] && !sv) hlt = 1'b1;
      end
      if (hlt) m_run = 1'b0;
      if (go) begin
         for (int t = 0; t <= tm; t++) begin
            w = '0;
            if (t == 0) w[53] = 1'b1;
            else if (t == 1) w[54] = 1'b1;
            else if (t == tm) w[55] = 1'b1;
            q.push_back('{w, t == 1, 2'b11, 3'(t), cur});
         end
         cur = 1'b0;
      end
      m_ien = cur;
   endtask

   task automatic run_instr(input logic [2:0] op, input logic ib, input logic [11:0] d, input logic fi, fo, sv,
                            input int smax, input int fstall, output int clks, output int im);
      logic an, az, ez;
      int ns;
      logic [55:1] e;
      an = 1'($urandom);
      az = 1'($urandom);
      ez = 1'($urandom);
      build(op, ib, d, fi, fo, sv, an, az, ez);
      clks = 0;
      im = 0;
      foreach (q[n]) begin
         ns = !q[n].mem ? 0 : (fstall >= 0 && q[n].cyc == 2'b01) ? fstall : int'($urandom_range(0, smax));
         for (int k = 0; k <= ns; k++) begin
            @(negedge clk);
            if (n == 0 && k == 0) begin
               op_code = op; i_bit = ib; d_bits = d; fgi = fi; fgo = fo; s_in = sv;
               ac_is_neg = an; ac_is_zero = az; e_is_zero = ez;
            end
            mem_ready = q[n].mem ? (k == ns) : 1'($urandom);
            mdr_is_zero = 1'($urandom);
            #1;
            clks++;
            if (o_cyc == 2'b01 && o_mreq) im++;
            e = (k == ns) ? q[n].cw : '0;
            total += 6;
            if (o_cw !== e) begin bad++; $display("FAIL step_cw op=%0d n=%0d k=%0d got=%h exp=%h", op, n, k, o_cw, e); end
            if (o_mreq !== q[n].mem) begin bad++; $display("FAIL step_mem_req n=%0d got=%b exp=%b", n, o_mreq, q[n].mem); end
            if (o_t !== q[n].t) begin bad++; $display("FAIL step_t n=%0d got=%0d exp=%0d", n, o_t, q[n].t); end
            if (o_cyc !== q[n].cyc) begin bad++; $display("FAIL step_cycle n=%0d got=%b exp=%b", n, o_cyc, q[n].cyc); end
            if (o_ien !== q[n].ien) begin bad++; $display("FAIL step_ien n=%0d got=%b exp=%b", n, o_ien, q[n].ien); end
            if (o_run !== 1'b1) begin bad++; $display("FAIL step_running n=%0d got=%b exp=1", n, o_run); end
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; s_in = 1'b0; mem_ready = 1'b0; fgi = 1'b0; fgo = 1'b0;
      @(negedge clk); #1;
      total += 6;
      if (o_cw !== '0) begin bad++; $display("FAIL reset_cw got=%h exp=0", o_cw); end
      if (o_mreq !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", o_mreq); end
      if (o_cyc !== 2'b00) begin bad++; $display("FAIL reset_cycle got=%b exp=00", o_cyc); end
      if (o_t !== 3'd0) begin bad++; $display("FAIL reset_t got=%0d exp=0", o_t); end
      if (o_run !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", o_run); end
      if (o_ien !== 1'b0) begin bad++; $display("FAIL reset_ien got=%b exp=0", o_ien); end
      @(negedge clk);
      reset_n = 1'b1;
      m_ien = 1'b0;
      m_run = 1'b0;
   endtask

   task automatic start();
      @(negedge clk);
      s_in = 1'b1;
      mem_ready = 1'b1;
      #1;
      total++;
      if (o_run !== 1'b0 || o_cw !== '0 || o_mreq !== 1'b0)
         begin bad++; $display("FAIL idle_before_start run=%b cw=%h mreq=%b exp=0/0/0", o_run, o_cw, o_mreq); end
      m_run = 1'b1;
   endtask

   task automatic test_lda();
      int c, m;
      test_reset();
      start();
      run_instr(3'd2, 1'b0, 12'h123, 1'b0, 1'b0, 1'b0, 0, -1, c, m);
      total++;
      if (c != 8) begin bad++; $display("FAIL lda_latency got=%0d exp=8", c); end
      @(negedge clk); #1;
      total++;
      if (o_cyc !== 2'b00 || o_t !== 3'd0) begin bad++; $display("FAIL lda_back_to_fetch got=%b/%0d exp=00/0", o_cyc, o_t); end
   endtask

   task automatic test_add_indirect_stall();
      int c, m;
      test_reset();
      start();
      run_instr(3'd1, 1'b1, 12'h0a5, 1'b0, 1'b0, 1'b0, 0, 3, c, m);
      total += 2;
      if (c != 15) begin bad++; $display("FAIL add_ind_latency got=%0d exp=15", c); end
      if (m != 4) begin bad++; $display("FAIL add_ind_mem_req_clocks got=%0d exp=4", m); end
   endtask

   task automatic test_interrupt();
      int c, m;
      test_reset();
      start();
      run_instr(3'd7, 1'b1, 12'h040, 1'b0, 1'b0, 1'b0, 0, -1, c, m);
      total++;
      if (o_ien !== 1'b1) begin bad++; $display("FAIL ion_ien got=%b exp=1", o_ien); end
      run_instr(3'd2, 1'b0, 12'h010, 1'b1, 1'b0, 1'b0, 1, -1, c, m);
      @(negedge clk); #1;
      total += 2;
      if (o_ien !== 1'b0) begin bad++; $display("FAIL int_ien_cleared got=%b exp=0", o_ien); end
      if (o_cyc !== 2'b00) begin bad++; $display("FAIL int_return_cycle got=%b exp=00", o_cyc); end
   endtask

   task automatic test_hlt();
      int c, m;
      test_reset();
      start();
      run_instr(3'd7, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 0, -1, c, m);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         s_in = 1'b0; mem_ready = 1'b1; fgi = 1'($urandom); op_code = 3'($urandom); d_bits = 12'($urandom);
         #1;
         total++;
         if (o_run !== 1'b0 || o_t !== 3'd0 || o_cyc !== 2'b00 || o_cw !== '0 || o_mreq !== 1'b0)
            begin bad++; $display("FAIL hlt_idle n=%0d run=%b t=%0d cyc=%b cw=%h mreq=%b exp=all 0", n, o_run, o_t, o_cyc, o_cw, o_mreq); end
      end
      start();
      run_instr(3'd7, 1'b0, 12'h001, 1'b0, 1'b0, 1'b1, 0, -1, c, m);
      run_instr(3'd0, 1'b0, 12'h055, 1'b0, 1'b0, 1'b0, 2, -1, c, m);
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      test_reset();
      start();
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         op_code = 3'd6; i_bit = 1'b0; mem_ready = 1'b1; s_in = 1'b0; fgi = 1'b0; fgo = 1'b0;
         #1;
         found = o_cyc == 2'b10 && o_t == 3'd3;
      end
      total++;
      if (!found) begin bad++; $display("FAIL isz_t3_reached got=0 exp=1"); end
      else begin
         mem_ready = 1'b0;
         #1;
         total += 2;
         if (o_mreq !== 1'b1) begin bad++; $display("FAIL isz_t3_mem_req got=%b exp=1", o_mreq); end
         if (o_cw !== '0) begin bad++; $display("FAIL isz_t3_stall_cw got=%h exp=0", o_cw); end
         @(negedge clk); #1;
         total++;
         if (o_t !== 3'd3) begin bad++; $display("FAIL isz_t3_hold got=%0d exp=3", o_t); end
         reset_n = 1'b0;
         #1;
         total++;
         if (o_cw !== '0 || o_mreq !== 1'b0 || o_cyc !== 2'b00 || o_t !== 3'd0 || o_run !== 1'b0 || o_ien !== 1'b0)
            begin bad++; $display("FAIL async_reset cw=%h mreq=%b cyc=%b t=%0d run=%b ien=%b exp=all 0", o_cw, o_mreq, o_cyc, o_t, o_run, o_ien); end
         mem_ready = 1'b1;
         @(negedge clk);
         reset_n = 1'b1;
         for (int n = 0; n < 2; n++) begin
            @(negedge clk); #1;
            total++;
            if (o_cw !== '0 || o_run !== 1'b0) begin bad++; $display("FAIL post_reset_quiet n=%0d cw=%h run=%b exp=0/0", n, o_cw, o_run); end
         end
      end
      m_ien = 1'b0;
      m_run = 1'b0;
   endtask

   task automatic test_tmax5();
      int c, m;
      sel5 = 1'b1;
      test_reset();
      start();
      run_instr(3'd2, 1'b0, 12'h321, 1'b0, 1'b0, 1'b0, 0, -1, c, m);
      total++;
      if (c != 12) begin bad++; $display("FAIL tmax5_latency got=%0d exp=12", c); end
      run_instr(3'd6, 1'b1, 12'h777, 1'b0, 1'b0, 1'b0, 2, -1, c, m);
      run_instr(3'd7, 1'b1, 12'h0c0, 1'b0, 1'b0, 1'b0, 2, -1, c, m);
      run_instr(3'd3, 1'b0, 12'h004, 1'b0, 1'b1, 1'b0, 2, -1, c, m);
      sel5 = 1'b0;
   endtask

   task automatic test_random();
      int c, m;
      test_reset();
      for (int n = 0; n < 40; n++) begin
         if (!m_run) start();
         run_instr(3'($urandom_range(0, 7)), 1'($urandom), 12'($urandom), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 3, -1, c, m);
      end
   endtask

   initial begin
      test_reset();
      test_lda();
      test_add_indirect_stall();
      test_interrupt();
      test_hlt();
      test_async_reset();
      test_tmax5();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
